activation_pipe: RTL and testbench

Parametrised successor to the single-mode ReLU activation stage. Takes the 2*DATA_WIDTH fixed-point accumulator result of a neuron and applies a per-beat selectable activation: ReLU, leaky ReLU, signed saturate (identity), or clipped ReLU. It then rescales to DATA_WIDTH with saturation. Sits between the neuron MAC/bias-add and the layer output buffer, with valid/ready handshakes on both sides, a 2-stage pipeline, and a saturation event counter for quantisation monitoring.

---
 rtl/activation_pkg.sv | 22 ++
 rtl/activation_core.sv | 75 +++++++
 rtl/activation_pipe.sv | 99 +++++++++
 tb/tb_activation_pipe.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/activation_pkg.sv
// Shared types and saturation constants for the activation pipeline.
// Mode encoding and DATA_WIDTH-parametrised saturation limit helpers.
package activation_pkg;

  typedef enum logic [1:0] {
    ACT_RELU,
    ACT_LEAKY,
    ACT_SAT,
    ACT_CLIP
  } act_mode_e;

  // Largest positive value of a dw-bit signed number, zero-extended.
  function automatic logic [63:0] sat_pos(input int unsigned dw);
    return (64'd1 << (dw - 1)) - 64'd1;
  endfunction

  // Most negative value of a dw-bit signed number, zero-extended.
  function automatic logic [63:0] sat_neg(input int unsigned dw);
    return 64'd1 << (dw - 1);
  endfunction

endpackage

// File: rtl/activation_core.sv
// Combinational activation, rescale and saturation of one accumulator.
// Ports: x (2*DW accumulator), mode, clip_max -> data (DW), sat flag.
module activation_core
  import activation_pkg::*;
#(
  parameter int DATA_WIDTH       = 16,
  parameter int WEIGHT_INT_WIDTH = 4,
  parameter int LEAK_SHIFT       = 3
) (
  input  logic [2*DATA_WIDTH-1:0] x,
  input  act_mode_e               mode,
  input  logic [DATA_WIDTH-1:0]   clip_max,
  output logic [DATA_WIDTH-1:0]   data,
  output logic                    sat
);

  localparam int N  = 2 * DATA_WIDTH;
  localparam int W  = WEIGHT_INT_WIDTH;
  localparam int DW = DATA_WIDTH;

  localparam logic [DW-1:0] POS = DW'(sat_pos(DW));
  localparam logic [DW-1:0] NEG = DW'(sat_neg(DW));

  logic signed [N-1:0] v;
  logic [W:0]          top;
  logic [DW-1:0]       slice;
  logic                fits;
  logic [DW-1:0]       relu;
  logic                relu_sat;

  always_comb begin
    v = x;
    if (mode == ACT_LEAKY && x[N-1])
      v = signed'(x) >>> LEAK_SHIFT;

    top   = v[N-1 -: W+1];
    slice = v[N-1-W -: DW];
    // Slice is exact only when the dropped top bits are pure sign.
    fits  = (top == '0) || (top == '1);

    relu     = slice;
    relu_sat = 1'b0;
    if (x[N-1]) begin
      relu = '0;
    end else if (top != '0) begin
      relu     = POS;
      relu_sat = 1'b1;
    end

    data = slice;
    sat  = 1'b0;
    unique case (1'b1)
      mode == ACT_RELU: begin
        data = relu;
        sat  = relu_sat;
      end
      mode == ACT_CLIP: begin
        if (relu > clip_max) begin
          data = clip_max;
          sat  = 1'b1;
        end else begin
          data = relu;
          sat  = relu_sat;
        end
      end
      default: begin
        if (!fits) begin
          data = v[N-1] ? NEG : POS;
          sat  = 1'b1;
        end
      end
    endcase
  end

endmodule

// File: rtl/activation_pipe.sv
// Two-stage valid/ready activation pipeline with saturation counter.
// Ports: in_* beat with mode/clip, out_* result, sat_clr/sat_count.
module activation_pipe
  import activation_pkg::*;
#(
  parameter int DATA_WIDTH       = 16,
  parameter int WEIGHT_INT_WIDTH = 4,
  parameter int LEAK_SHIFT       = 3,
  parameter int SAT_CNT_WIDTH    = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2*DATA_WIDTH-1:0]  in_data,
  input  logic [1:0]               in_mode,
  input  logic [DATA_WIDTH-1:0]    in_clip_max,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic                     out_sat,
  input  logic                     sat_clr,
  output logic [SAT_CNT_WIDTH-1:0] sat_count
);

  localparam int N  = 2 * DATA_WIDTH;
  localparam int DW = DATA_WIDTH;

  logic          s1_valid;
  logic [N-1:0]  s1_data;
  act_mode_e     s1_mode;
  logic [DW-1:0] s1_clip;

  logic          s2_valid;
  logic          s1_adv;
  logic          s2_adv;
  logic [DW-1:0] core_data;
  logic          core_sat;

  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = s2_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_mode  <= ACT_RELU;
      s1_clip  <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_data <= in_data;
        s1_mode <= act_mode_e'(in_mode);
        s1_clip <= in_clip_max;
      end
    end
  end

  activation_core #(
    .DATA_WIDTH      (DATA_WIDTH),
    .WEIGHT_INT_WIDTH(WEIGHT_INT_WIDTH),
    .LEAK_SHIFT      (LEAK_SHIFT)
  ) u_core (
    .x       (s1_data),
    .mode    (s1_mode),
    .clip_max(s1_clip),
    .data    (core_data),
    .sat     (core_sat)
  );

  // Output registers only load on a real beat so data holds in stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      out_data <= '0;
      out_sat  <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= core_data;
        out_sat  <= core_sat;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_count <= '0;
    end else if (sat_clr) begin
      sat_count <= '0;
    end else if (out_valid && out_ready && out_sat &&
                 sat_count != '1) begin
      sat_count <= sat_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_activation_pipe.sv
// Scoreboard testbench for activation_pipe with directed vectors.
// Driver pushes expected results; a negedge monitor pops and compares.
module tb_activation_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [1:0]  in_mode;
  logic [15:0] in_clip_max;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_sat;
  logic        sat_clr;
  logic [5:0]  sat_count;

  int n_vec = 0;
  int n_err = 0;

  logic [16:0] q[$];

  activation_pipe #(
    .DATA_WIDTH      (16),
    .WEIGHT_INT_WIDTH(4),
    .LEAK_SHIFT      (3),
    .SAT_CNT_WIDTH   (6)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_mode    (in_mode),
    .in_clip_max(in_clip_max),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_sat    (out_sat),
    .sat_clr    (sat_clr),
    .sat_count  (sat_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: got timeout expected progress", name);
  endtask

  task automatic send(input logic [31:0] d, input logic [1:0] m,
                      input logic [15:0] c, input logic [15:0] ed,
                      input logic es);
    int t;
    t = 0;
    in_data     = d;
    in_mode     = m;
    in_clip_max = c;
    in_valid    = 1'b1;
    @(negedge clk);
    while (!in_ready && t < 100) begin
      t++;
      @(negedge clk);
    end
    if (!in_ready) fail_now("send_wait");
    else q.push_back({es, ed});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_lat(input string name, input logic [31:0] d,
                          input logic [1:0] m, input logic [15:0] ed,
                          input logic es);
    send(d, m, 16'h0000, ed, es);
    @(negedge clk);
    chk({name, "_lat1"}, {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    chk({name, "_lat2"}, {31'd0, out_valid}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while ((q.size() != 0 || out_valid) && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) fail_now(name);
    @(posedge clk);
    #1;
  endtask

  // Monitor: scoreboard pops, stall stability, in_ready availability.
  initial begin
    logic        held;
    logic [16:0] hv;
    logic [16:0] e;
    held = 1'b0;
    hv   = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        held = 1'b0;
      end else begin
        if (!out_valid || out_ready)
          chk("in_ready_free", {31'd0, in_ready}, 32'd1);
        if (held && out_valid)
          chk("stall_hold", {15'd0, out_sat, out_data}, {15'd0, hv});
        held = out_valid && !out_ready;
        hv   = {out_sat, out_data};
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            chk("unexpected_beat", {15'd0, out_sat, out_data}, 32'hFFFF_FFFF);
          end else begin
            e = q.pop_front();
            chk("beat", {15'd0, out_sat, out_data}, {15'd0, e});
          end
        end
      end
    end
  end

  initial begin
    logic        done;
    logic        pat[6];
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_data     = '0;
    in_mode     = '0;
    in_clip_max = '0;
    out_ready   = 1'b1;
    sat_clr     = 1'b0;
    pat = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {16'd0, out_data}, 32'd0);
    chk("rst_out_sat", {31'd0, out_sat}, 32'd0);
    chk("rst_sat_count", {26'd0, sat_count}, 32'd0);
    @(posedge clk);
    #1;

    // Basic ReLU and latency.
    send_lat("relu_pos", 32'h0123_4000, 2'd0, 16'h1234, 1'b0);
    send(32'hFFFF_F000, 2'd0, 16'h0000, 16'h0000, 1'b0);
    drain("drain_t1");
    chk("cnt_t1", {26'd0, sat_count}, 32'd0);

    // Saturation in ReLU and identity.
    send(32'h0800_0000, 2'd0, 16'h0000, 16'h7FFF, 1'b1);
    drain("drain_t2a");
    chk("cnt_t2a", {26'd0, sat_count}, 32'd1);
    send(32'hF000_0000, 2'd2, 16'h0000, 16'h8000, 1'b1);
    drain("drain_t2b");
    chk("cnt_t2b", {26'd0, sat_count}, 32'd2);

    // Leaky negative slope and clip ceiling.
    send(32'hFFFF_0000, 2'd1, 16'h0000, 16'hFFFE, 1'b0);
    send(32'h0200_0000, 2'd3, 16'h1000, 16'h1000, 1'b1);
    drain("drain_t3");
    chk("cnt_t3", {26'd0, sat_count}, 32'd3);

    // Back-to-back stream under a stalling sink.
    done = 1'b0;
    fork
      begin
        send(32'h0001_2000, 2'd0, 16'h0000, 16'h0012, 1'b0);
        send(32'hFFF8_0000, 2'd1, 16'h0000, 16'hFFF0, 1'b0);
        send(32'h07FF_F000, 2'd2, 16'h0000, 16'h7FFF, 1'b0);
        send(32'h0005_0000, 2'd3, 16'h0100, 16'h0050, 1'b0);
        send(32'h1000_0000, 2'd2, 16'h0000, 16'h7FFF, 1'b1);
        send(32'h8000_0000, 2'd0, 16'h0000, 16'h0000, 1'b0);
        send(32'h4000_0000, 2'd3, 16'h7FFF, 16'h7FFF, 1'b1);
        send(32'h0034_5000, 2'd1, 16'h0000, 16'h0345, 1'b0);
        drain("drain_t4");
        done = 1'b1;
      end
      begin
        int k;
        k = 0;
        while (!done) begin
          out_ready = pat[k % 6];
          k++;
          @(posedge clk);
          #1;
        end
      end
    join
    out_ready = 1'b1;
    chk("cnt_t4", {26'd0, sat_count}, 32'd5);

    // Counter saturates at all-ones.
    for (int i = 0; i < 60; i++)
      send(32'h0800_0000, 2'd0, 16'h0000, 16'h7FFF, 1'b1);
    drain("drain_t5");
    chk("cnt_full", {26'd0, sat_count}, 32'd63);

    // Clear wins over a simultaneous saturated transfer.
    send(32'h0800_0000, 2'd0, 16'h0000, 16'h7FFF, 1'b1);
    @(posedge clk);
    #1;
    sat_clr = 1'b1;
    @(posedge clk);
    #1;
    sat_clr = 1'b0;
    @(negedge clk);
    chk("cnt_clr", {26'd0, sat_count}, 32'd0);
    drain("drain_t5b");

    // Asynchronous reset with beats in flight.
    send(32'h0800_0000, 2'd0, 16'h0000, 16'h7FFF, 1'b1);
    drain("drain_t6a");
    chk("cnt_t6", {26'd0, sat_count}, 32'd1);
    out_ready = 1'b0;
    send(32'h0800_0000, 2'd0, 16'h0000, 16'h7FFF, 1'b1);
    send(32'h0001_2000, 2'd0, 16'h0000, 16'h0012, 1'b0);
    chk("inflight_valid", {31'd0, out_valid}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_data", {16'd0, out_data}, 32'd0);
    chk("arst_sat", {31'd0, out_sat}, 32'd0);
    chk("arst_count", {26'd0, sat_count}, 32'd0);
    q.delete();
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    send_lat("post_rst", 32'h0034_5000, 2'd1, 16'h0345, 1'b0);
    drain("drain_t6b");
    chk("cnt_post_rst", {26'd0, sat_count}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
